// File: rtl/imem_fetch_arbiter.sv
// Shares one synchronous byte-wide instruction RAM port between a 32-bit fetch
// sequencer (four byte reads, little-endian) and a single-cycle program loader.
module imem_fetch_arbiter #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          i_Clk,
    input  logic          i_Rst_n,
    input  logic          i_Fetch_Req,
    input  logic [31:0]   i_Fetch_Addr,
    output logic          o_Fetch_Ready,
    input  logic          i_Flush,
    output logic [31:0]   o_Instruction,
    output logic          o_Instr_Valid,
    output logic          o_Fetch_Err,
    input  logic          i_Load_We,
    input  logic [31:0]   i_Load_Addr,
    input  logic [7:0]    i_Load_Data,
    output logic          o_Load_Ready,
    output logic [AW-1:0] o_Mem_Addr,
    output logic          o_Mem_We,
    output logic [7:0]    o_Mem_Wdata,
    input  logic [7:0]    i_Mem_Rdata
);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_TAIL, S_ERR} state_t;

    state_t          state_reg, state_next;
    logic [1:0]      k_reg, k_next;
    logic [AW-1:0]   base_reg, base_next;
    logic [2:0][7:0] lane_reg;
    logic [2:0]      lane_hit;
    logic [31:0]     instr_reg;
    logic            valid_reg;
    logic            err_reg;
    logic            fetch_bad;
    logic            unused_load_addr;

    // Out of range means any address bit at or above AW is set.
    assign fetch_bad        = (i_Fetch_Addr[1:0] != 2'b00) || (i_Fetch_Addr[31:AW] != '0);
    assign unused_load_addr = ^i_Load_Addr[31:AW];

    // Byte k-1 arrives while the read counter shows k.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_lane
            assign lane_hit[gi] = (state_reg == S_RD) && (k_reg == 2'(gi + 1));
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        k_next        = k_reg;
        base_next     = base_reg;
        o_Fetch_Ready = 1'b0;
        o_Load_Ready  = 1'b0;
        o_Mem_We      = 1'b0;
        o_Mem_Addr    = '0;
        o_Mem_Wdata   = '0;
        case (state_reg)
            S_IDLE: begin
                if (i_Load_We) begin
                    o_Load_Ready = 1'b1;
                    o_Mem_We     = 1'b1;
                    o_Mem_Addr   = i_Load_Addr[AW-1:0];
                    o_Mem_Wdata  = i_Load_Data;
                end else if (i_Fetch_Req && !i_Flush) begin
                    o_Fetch_Ready = 1'b1;
                    base_next     = i_Fetch_Addr[AW-1:0];
                    k_next        = 2'd0;
                    state_next    = fetch_bad ? S_ERR : S_RD;
                end
            end
            S_RD: begin
                o_Mem_Addr = base_reg + AW'(k_reg);
                if (i_Flush) begin
                    state_next = S_IDLE;
                    k_next     = 2'd0;
                end else begin
                    k_next = k_reg + 2'd1;
                    if (k_reg == 2'd3) begin
                        state_next = S_TAIL;
                    end
                end
            end
            S_TAIL:  state_next = S_IDLE;
            S_ERR:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        // Handshakes and RAM strobes are forced quiet while reset is held.
        if (!i_Rst_n) begin
            o_Fetch_Ready = 1'b0;
            o_Load_Ready  = 1'b0;
            o_Mem_We      = 1'b0;
            o_Mem_Addr    = '0;
            o_Mem_Wdata   = '0;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_reg <= S_IDLE;
            k_reg     <= 2'd0;
            base_reg  <= '0;
            lane_reg  <= '0;
            instr_reg <= '0;
            valid_reg <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            k_reg     <= k_next;
            base_reg  <= base_next;
            for (int i = 0; i < 3; i++) begin
                if (lane_hit[i]) begin
                    lane_reg[i] <= i_Mem_Rdata;
                end
            end
            valid_reg <= !i_Flush && ((state_reg == S_TAIL) || (state_reg == S_ERR));
            err_reg   <= !i_Flush && (state_reg == S_ERR);
            if ((state_reg == S_TAIL) && !i_Flush) begin
                instr_reg <= {i_Mem_Rdata, lane_reg[2], lane_reg[1], lane_reg[0]};
            end
        end
    end

    assign o_Instruction = instr_reg;
    assign o_Instr_Valid = valid_reg;
    assign o_Fetch_Err   = err_reg;

endmodule
